// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: 8-digit multiplexed seven-segment controller with a round-robin write port pair and blanked scan
module seg_display_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_addr,
  input  logic [3:0] req0_data,
  input  logic       req0_en,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_addr,
  input  logic [3:0] req1_data,
  input  logic       req1_en,
  output logic [6:0] data_out,
  output logic [7:0] data_pos
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BL = PW'(BLANK_CYCLES);
  logic [PW-1:0] presc;
  logic [2:0] idx;
  logic [7:0][3:0] buffer;
  logic [7:0] en;
  logic prio;
  logic lit;
  logic [6:0] seg;
  assign req0_ready = rst & req0_valid & (~req1_valid | ~prio);
  assign req1_ready = rst & req1_valid & (~req0_valid | prio);
  assign lit = (presc >= BL) && en[idx];
  always_comb begin
    seg = 7'b0000000;
    case (buffer[idx])
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      idx      <= '0;
      buffer   <= '0;
      en       <= '0;
      prio     <= 1'b0;
      data_out <= '0;
      data_pos <= '0;
    end else begin
      presc    <= (presc == LAST) ? '0 : presc + 1'b1;
      idx      <= (presc == LAST) ? idx + 1'b1 : idx;
      data_out <= lit ? seg : '0;
      data_pos <= lit ? 8'b1 << idx : '0;
      // ready signals are mutually exclusive, so at most one branch fires
      if (req0_ready) begin
        buffer[req0_addr] <= req0_data;
        en[req0_addr]     <= req0_en;
        prio              <= 1'b1;
      end else if (req1_ready) begin
        buffer[req1_addr] <= req1_data;
        en[req1_addr]     <= req1_en;
        prio              <= 1'b0;
      end
    end
  end
endmodule
